rxuart_param: RTL and testbench
===============================

Name: rxuart_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver used for PMod host links.
- Configurable data width, parity mode and stop-bit count.
- Synchronises the raw RX pin and reports parity error, framing error and break per received character.
- Output feeds command decoders, e.g. the Neopixel frame loader, as a one-cycle valid strobe with held data.

Parameters:
- CLKS_PER_BAUD, 2604, clock cycles per bit (50 MHz / 19200); legal range >= 8.
- DATA_BITS, 8, data bits per character; legal 5..9; LSB is received first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_uart_rx  in  1  raw asynchronous serial input; idles high.
- o_rx_data  out  DATA_BITS  last received character; held until the next o_rx_valid.
- o_rx_valid  out  1  one-cycle strobe; character and status flags are valid.
- o_parity_err  out  1  parity mismatch on the last character; 0 when PARITY=0.
- o_frame_err  out  1  at least one stop bit sampled low.
- o_break  out  1  break condition: data, parity and stop bits all sampled 0.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low, on i_rst_n.
  - Reset values: synchroniser flops = 1, state = IDLE, counters = 0, o_rx_data = 0, all flags = 0, o_busy = 0.
  - Reset mid-frame abandons the frame immediately. No o_rx_valid is produced for that frame.
- Input path: 2-flop synchroniser on i_uart_rx. All decisions use the synchronised signal rx_s.
- Sample point: half = (CLKS_PER_BAUD-1)/2, using integer division.
- Baud counter: 32 bits wide; reset to 0 on every state entry.
- State machine:
  - IDLE: rx_s == 0 -> START.
  - START: at count == half, if rx_s == 0 -> DATA with count reset and bit index 0; else -> IDLE (glitch rejected, no flags).
  - DATA: every CLKS_PER_BAUD cycles, sample rx_s into data[bit]. After bit DATA_BITS-1 -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: after CLKS_PER_BAUD cycles, sample the parity bit, then -> STOP.
    - Odd mode: XOR of data and parity bit must be 1.
    - Even mode: the XOR must be 0.
  - STOP: sample each stop bit after CLKS_PER_BAUD cycles.
    - After the last stop sample, all of the following happen on the next clock edge: o_rx_data and flags load, o_rx_valid = 1 for exactly 1 cycle.
    - If the last stop bit sampled 1 -> IDLE.
    - Otherwise -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then -> IDLE. This prevents a held-low line from being read as repeated characters.
- Return to IDLE happens at mid-stop-bit, so a start bit that immediately follows the stop bit is detected.
- Flags:
  - Update only together with o_rx_valid and hold until the next strobe.
  - o_break implies o_frame_err.
  - A parity error and a framing error may both be set.
- Latency: o_rx_valid rises 3 cycles after the stop-bit midpoint at the pin (2 synchroniser cycles + 1 register cycle).
- With 2 stop bits, o_frame_err is set if either stop bit is 0.

Optional Feature:
- Macro: RXUART_MAJORITY_EN.
- Defined:
  - Each start, data, parity and stop sample is the 2-of-3 majority of rx_s at counts half-1, half and half+1.
  - The decision is taken at half+1.
  - START validation also uses the majority value.
  - Downstream timing stays relative to that point: later bit boundaries remain CLKS_PER_BAUD apart.
- Undefined: single sample at count == half. No majority logic is instantiated.

Test Plan:
- CLKS_PER_BAUD=16, 8N1, send 0xA5 -> one o_rx_valid pulse, o_rx_data=0xA5, all flags 0, o_busy low afterwards.
- PARITY=2, send 0x37 with parity bit 0 (correct bit is 1) -> o_rx_data=0x37, o_parity_err=1. Then send 0x37 with parity bit 1 -> o_parity_err=0.
- Stop bit driven 0, then line released high after 2 more bit times -> o_frame_err=1. Exactly one valid pulse; no second character while the line is low.
- Line held low for 12 bit times (8N1) -> one valid pulse with o_rx_data=0x00, o_frame_err=1, o_break=1. Receiver returns to IDLE only after the line goes high.
- Low glitch of 3 clocks on idle line -> no o_rx_valid; back to IDLE by count half+1. With RXUART_MAJORITY_EN, a 1-clock inversion at mid-bit of 0xFF data -> o_rx_data=0xFF.
- Assert i_rst_n=0 during data bit 4 of a frame, release, then send 0x3C -> no valid for the aborted frame; next pulse carries o_rx_data=0x3C.

Source files
------------

// File: rtl/rxuart_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits.
// Define RXUART_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module rxuart_param #(
    parameter int CLKS_PER_BAUD = 2604,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam logic [31:0] HALF = 32'((CLKS_PER_BAUD - 1) / 2);
    localparam logic [31:0] LAST = 32'(CLKS_PER_BAUD - 1);
`ifdef RXUART_MAJORITY_EN
    localparam logic [31:0] DECIDE = HALF + 32'd1;
`else
    localparam logic [31:0] DECIDE = HALF;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [1:0]           sync_q;
    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ones_q, ones_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 frame_q, frame_d;
    logic                 brk_q, brk_d;
    logic                 rx_s;
    logic                 smp;
    logic                 ferr_now;
    logic                 ones_now;

    assign rx_s = sync_q[1];

`ifdef RXUART_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hist_q <= 2'b11;
        else          hist_q <= {hist_q[0], rx_s};
    end

    assign smp = (hist_q[1] & hist_q[0]) |
                 (hist_q[1] & rx_s) |
                 (hist_q[0] & rx_s);
`else
    assign smp = rx_s;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ones_d   = ones_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = perr_q;
        frame_d  = frame_q;
        brk_d    = brk_q;
        ferr_now = ferr_q | ~smp;
        ones_now = ones_q | smp;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == DECIDE) begin
                    cnt_d = '0;
                    if (!smp) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                        ones_d  = 1'b0;
                        ferr_d  = 1'b0;
                        par_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {smp, shift_q[DATA_BITS-1:1]};
                    ones_d  = ones_now;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = smp;
                    ones_d  = ones_now;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        frame_d = ferr_now;
                        brk_d   = ~ones_now;
                        if (PARITY == 1)      perr_d = ~(^shift_q ^ par_q);
                        else if (PARITY == 2) perr_d = ^shift_q ^ par_q;
                        else                  perr_d = 1'b0;
                        // A low stop bit must see the line rise before re-arming.
                        state_d = smp ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        ferr_d = ferr_now;
                        ones_d = ones_now;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ones_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            frame_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_uart_rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ones_q  <= ones_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            frame_q <= frame_d;
            brk_q   <= brk_d;
        end
    end

    assign o_rx_data    = data_q;
    assign o_rx_valid   = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = frame_q;
    assign o_break      = brk_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_rxuart_param.sv
// Directed bench for rxuart_param: 8N1 instance (a) and 8E2 instance (b),
// 16 clocks per bit.
module tb_rxuart_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b;
    logic [7:0] da, db;
    logic       va, pa, fa, ba, bsa;
    logic       vb, pb, fb, bb, bsb;
    int         vcnt_a = 0;
    int         vcnt_b = 0;
    int         total = 0;
    int         bad = 0;
    int         base;
    logic [15:0] f;

    always #5 clk = ~clk;

    rxuart_param #(
        .CLKS_PER_BAUD(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_a),
        .o_rx_data(da), .o_rx_valid(va), .o_parity_err(pa),
        .o_frame_err(fa), .o_break(ba), .o_busy(bsa)
    );

    rxuart_param #(
        .CLKS_PER_BAUD(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx_b),
        .o_rx_data(db), .o_rx_valid(vb), .o_parity_err(pb),
        .o_frame_err(fb), .o_break(bb), .o_busy(bsb)
    );

    always @(posedge clk) begin
        if (va) vcnt_a <= vcnt_a + 1;
        if (vb) vcnt_b <= vcnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // bits[0] goes out first; line is left at fin afterwards.
    task automatic send(input int which, input logic [15:0] bits,
                        input int n, input logic fin);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_b = bits[i];
            repeat (16) @(negedge clk);
        end
        if (which == 0) rx_a = fin;
        else            rx_b = fin;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data", {24'd0, da}, 0);
        chk("rst_valid", va, 0);
        chk("rst_flags", {pa, fa, ba}, 0);
        chk("rst_busy", bsa, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5
        base = vcnt_a;
        f = {6'h3F, 1'b1, 8'hA5, 1'b0};
        send(0, f, 10, 1'b1);
        repeat (32) @(negedge clk);
        chk("a5_cnt", vcnt_a - base, 1);
        chk("a5_data", {24'd0, da}, 32'hA5);
        chk("a5_flags", {pa, fa, ba}, 0);
        chk("a5_busy", bsa, 0);

        // back-to-back frames, no idle gap
        base = vcnt_a;
        f = {6'h3F, 1'b1, 8'h12, 1'b0};
        send(0, f, 10, 1'b1);
        f = {6'h3F, 1'b1, 8'h34, 1'b0};
        send(0, f, 10, 1'b1);
        repeat (32) @(negedge clk);
        chk("b2b_cnt", vcnt_a - base, 2);
        chk("b2b_data", {24'd0, da}, 32'h34);

        // even parity, wrong parity bit
        base = vcnt_b;
        f = {4'hF, 1'b1, 1'b1, 1'b0, 8'h37, 1'b0};
        send(1, f, 12, 1'b1);
        repeat (32) @(negedge clk);
        chk("pe_cnt", vcnt_b - base, 1);
        chk("pe_data", {24'd0, db}, 32'h37);
        chk("pe_perr", pb, 1);
        chk("pe_ferr", fb, 0);

        // even parity, correct parity bit
        f = {4'hF, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0};
        send(1, f, 12, 1'b1);
        repeat (32) @(negedge clk);
        chk("pok_cnt", vcnt_b - base, 2);
        chk("pok_perr", pb, 0);

        // second stop bit low on the 2-stop instance
        f = {4'hF, 1'b0, 1'b1, 1'b1, 8'h37, 1'b0};
        send(1, f, 12, 1'b1);
        repeat (32) @(negedge clk);
        chk("s2_cnt", vcnt_b - base, 3);
        chk("s2_ferr", fb, 1);
        chk("s2_perr", pb, 0);
        chk("s2_brk", bb, 0);
        chk("s2_busy", bsb, 0);

        // stop bit low, line low two more bit times
        base = vcnt_a;
        f = {4'h0, 2'b00, 1'b0, 8'h55, 1'b0};
        send(0, f, 12, 1'b1);
        repeat (48) @(negedge clk);
        chk("fe_cnt", vcnt_a - base, 1);
        chk("fe_data", {24'd0, da}, 32'h55);
        chk("fe_ferr", fa, 1);
        chk("fe_brk", ba, 0);
        chk("fe_busy", bsa, 0);

        // break: line low 12 bit times
        base = vcnt_a;
        f = 16'h0000;
        send(0, f, 12, 1'b0);
        chk("brk_cnt", vcnt_a - base, 1);
        chk("brk_data", {24'd0, da}, 0);
        chk("brk_flags", {pa, fa, ba}, 3'b011);
        chk("brk_busy_low", bsa, 1);
        repeat (16) @(negedge clk);
        chk("brk_busy_held", bsa, 1);
        chk("brk_cnt_held", vcnt_a - base, 1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("brk_busy_rel", bsa, 0);

        // 3-clock glitch on idle line
        base = vcnt_a;
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("gl_busy_in", bsa, 1);
        repeat (10) @(negedge clk);
        chk("gl_busy_out", bsa, 0);
        repeat (32) @(negedge clk);
        chk("gl_cnt", vcnt_a - base, 0);

`ifdef RXUART_MAJORITY_EN
        // 1-clock inversion at mid-bit of every data bit of 0xFF
        base = vcnt_a;
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_a = 1'b1;
            repeat (8) @(negedge clk);
            rx_a = 1'b0;
            @(negedge clk);
            rx_a = 1'b1;
            repeat (7) @(negedge clk);
        end
        rx_a = 1'b1;
        repeat (48) @(negedge clk);
        chk("maj_cnt", vcnt_a - base, 1);
        chk("maj_data", {24'd0, da}, 32'hFF);
        chk("maj_ferr", fa, 0);
`endif

        // reset during data bit 4
        base = vcnt_a;
        f = {6'h3F, 1'b1, 8'hFF, 1'b0};
        send(0, f, 5, 1'b1);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("ab_busy_pre", bsa, 1);
        rst_n = 1'b0;
        #1;
        chk("ab_busy_rst", bsa, 0);
        chk("ab_data_rst", {24'd0, da}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (64) @(negedge clk);
        chk("ab_cnt", vcnt_a - base, 0);
        f = {6'h3F, 1'b1, 8'h3C, 1'b0};
        send(0, f, 10, 1'b1);
        repeat (32) @(negedge clk);
        chk("ab_next_cnt", vcnt_a - base, 1);
        chk("ab_next_data", {24'd0, da}, 32'h3C);
        chk("ab_next_flags", {pa, fa, ba}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
